// File: rtl/cr_kme_drng_pkg.sv
// Shared types and widths for the KME DRNG read/reseed controller.
// Imported by the seed packer and the controller top level.
package cr_kme_drng_pkg;

    typedef enum logic [2:0] {
        SEED_GATHER,
        START,
        WAIT_RUN,
        COLLECT,
        PRESENT
    } drng_rd_fsm;

    localparam int SEED_BEATS = 3;
    localparam int DRNG_W     = 128;
    localparam int SEED_W     = 384;
    localparam int LIFE_W     = 48;
    localparam int KEY_W      = 256;

endpackage

// File: rtl/cr_kme_drng_seed_pack.sv
// Three-beat entropy packer building the 384-bit DRNG seed.
// The lifetime is latched with beat 0; done pulses with the last beat.
module cr_kme_drng_seed_pack
    import cr_kme_drng_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              gather,
    input  logic              ent_valid,
    input  logic [DRNG_W-1:0] ent_data,
    input  logic [LIFE_W-1:0] cfg_seed_life,
    output logic [SEED_W-1:0] seed,
    output logic [LIFE_W-1:0] seed_life,
    output logic              done
);

    localparam logic [1:0] LAST_BEAT = 2'(SEED_BEATS - 1);

    logic [1:0] beat;
    logic       take;

    assign take = gather & ent_valid;
    assign done = take && (beat == LAST_BEAT);

    // Beat counter plus seed/lifetime registers, highest slice first.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat      <= 2'd0;
            seed      <= '0;
            seed_life <= '0;
        end else if (take) begin
            case (beat)
                2'd0: begin
                    seed[SEED_W-1 -: DRNG_W] <= ent_data;
                    seed_life                <= cfg_seed_life;
                end
                2'd1:    seed[SEED_W-DRNG_W-1 -: DRNG_W] <= ent_data;
                default: seed[DRNG_W-1:0]                <= ent_data;
            endcase
            beat <= done ? 2'd0 : beat + 2'd1;
        end
    end

endmodule

// File: rtl/cr_kme_drng_rd_ctl.sv
// KME DRNG consumer: reseeds from entropy on expiry, pops DRNG
// words and presents packed 256-bit keys on a valid/ready port.
module cr_kme_drng_rd_ctl
    import cr_kme_drng_pkg::*;
#(
    parameter int KEY_WORDS = 2,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              drng_valid,
    input  logic [DRNG_W-1:0] drng_256_out,
    output logic              drng_ack,
    input  logic              seed_expired,
    output logic              drng_start,
    output logic [SEED_W-1:0] drng_seed,
    output logic [LIFE_W-1:0] drng_seed_life,
    input  logic [LIFE_W-1:0] cfg_seed_life,
    input  logic              ent_valid,
    input  logic [DRNG_W-1:0] ent_data,
    output logic              ent_ready,
    output logic              key_valid,
    output logic [KEY_W-1:0]  key_data,
    input  logic              key_ready,
    output logic [CNT_W-1:0]  reseed_cnt
);

    localparam logic [1:0]       KW      = 2'(KEY_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    drng_rd_fsm       state;
    drng_rd_fsm       state_nxt;
    logic [1:0]       wcnt;
    logic [KEY_W-1:0] key_q;
    logic             seed_done;
    logic             last_word;

    // Held low while rst is asserted so every output reads 0 in reset.
    assign ent_ready  = (state == SEED_GATHER) && !rst;
    assign drng_start = (state == START);
    assign drng_ack   = (state == COLLECT) && drng_valid;
    assign key_valid  = (state == PRESENT);
    assign key_data   = key_q;
    assign last_word  = drng_ack && ((wcnt + 2'd1) == KW);

    cr_kme_drng_seed_pack u_seed_pack (
        .clk           (clk),
        .rst           (rst),
        .gather        (ent_ready),
        .ent_valid     (ent_valid),
        .ent_data      (ent_data),
        .cfg_seed_life (cfg_seed_life),
        .seed          (drng_seed),
        .seed_life     (drng_seed_life),
        .done          (seed_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= SEED_GATHER;
        else     state <= state_nxt;
    end

    // Next state; a pending DRNG word always wins over a reseed.
    always_comb begin
        state_nxt = state;
        case (state)
            SEED_GATHER: if (seed_done) state_nxt = START;
            START:       state_nxt = WAIT_RUN;
            WAIT_RUN:    if (!seed_expired) state_nxt = COLLECT;
            COLLECT: begin
                if (last_word)
                    state_nxt = PRESENT;
                else if (!drng_valid && seed_expired)
                    state_nxt = SEED_GATHER;
            end
            PRESENT:     if (key_ready) state_nxt = COLLECT;
            default:     state_nxt = SEED_GATHER;
        endcase
    end

    // Key packing: word 0 fills the upper half, word 1 the lower.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt  <= 2'd0;
            key_q <= '0;
        end else if (drng_ack) begin
            if (wcnt == 2'd0) key_q[KEY_W-1 -: DRNG_W] <= drng_256_out;
            else              key_q[DRNG_W-1:0]        <= drng_256_out;
            wcnt <= wcnt + 2'd1;
        end else if (key_valid && key_ready) begin
            wcnt <= 2'd0;
        end
    end

    // Completed reseeds, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            reseed_cnt <= '0;
        else if (drng_start && (reseed_cnt != '1))
            reseed_cnt <= reseed_cnt + CNT_ONE;
    end

endmodule
